pipelined_prefix_adder: RTL

PIPELINED_PREFIX_ADDER -- requirements
Module: pipelined_prefix_adder

---
 rtl/adder_pkg.sv | 33 +++
 rtl/pipelined_prefix_adder_gp_combine.sv | 18 +
 rtl/pipelined_prefix_adder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// adder_pkg
// Shared types and helpers for the pipelined prefix adder.
//   gp_t            : one (generate, propagate) pair
//   LEGAL_WIDTHS    : operand widths the adder supports
//   clog2()         : ceiling log2, usable in constant expressions
//   is_legal_width(): true when a width appears in LEGAL_WIDTHS
package adder_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  localparam int NUM_LEGAL_WIDTHS = 5;
  localparam int LEGAL_WIDTHS [NUM_LEGAL_WIDTHS] = '{4, 8, 16, 32, 64};

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  function automatic bit is_legal_width(input int w);
    for (int i = 0; i < NUM_LEGAL_WIDTHS; i++) begin
      if (LEGAL_WIDTHS[i] == w) return 1'b1;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/pipelined_prefix_adder_gp_combine.sv
// gp_combine
// Prefix operator for (G,P) pairs: merges a higher group onto the
// adjacent lower group.
//   gp_hi  : pair for the more significant group
//   gp_lo  : pair for the less significant group
//   gp_res : merged pair covering both groups
module gp_combine
  import adder_pkg::*;
(
  input  gp_t gp_hi,
  input  gp_t gp_lo,
  output gp_t gp_res
);

  assign gp_res.g = gp_hi.g | (gp_hi.p & gp_lo.g);
  assign gp_res.p = gp_hi.p & gp_lo.p;

endmodule

// File: rtl/pipelined_prefix_adder.sv
// pipelined_prefix_adder
// Brent-Kung prefix adder/subtractor with a valid/ready stream interface.
// Stage 0 forms per-bit (g,p); stages 1..LEVELS are the up-sweep then
// down-sweep of the tree; a final registered stage forms sum/c_out/ovf.
// With PIPE=1 every stage is registered, with PIPE=0 only the result is.
// The whole pipe stalls together whenever a result is waiting un-taken.
//   clk, rst_n          : clock, async active-low reset
//   in_valid, in_ready  : operand handshake
//   a, b, c_in, sub     : operands; sub=1 computes a-b and ignores c_in
//   out_valid, out_ready: result handshake
//   sum, c_out, ovf     : result, carry/no-borrow, signed overflow
module pipelined_prefix_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int PIPE  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int LOG_W  = clog2(WIDTH);
  localparam int LEVELS = 2 * LOG_W - 1;

  if (!is_legal_width(WIDTH)) begin : g_bad_width
    $fatal(1, "pipelined_prefix_adder: unsupported WIDTH %0d", WIDTH);
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign b_eff    = b ^ {WIDTH{sub}};

  for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
    gp_t  [WIDTH-1:0] gp_d;
    gp_t  [WIDTH-1:0] gp_q;
    logic [WIDTH-1:0] p_d;
    logic [WIDTH-1:0] p_q;
    logic             ci_d;
    logic             ci_q;
    logic             v_d;
    logic             v_q;

    if (k == 0) begin : g_in
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign gp_d[i].g = a[i] & b_eff[i];
        assign gp_d[i].p = a[i] ^ b_eff[i];
      end
      assign p_d  = a ^ b_eff;
      // Subtraction is a + ~b + 1, so the carry-in is forced to 1.
      assign ci_d = sub | c_in;
      assign v_d  = in_valid;
    end else begin : g_tree
      // Levels 1..LOG_W sweep up with span 2^k; the remaining levels
      // sweep back down filling the odd-position prefixes.
      localparam bit IS_UP = (k <= LOG_W);
      localparam int DEPTH = IS_UP ? k : (2 * LOG_W - k);
      localparam int SPAN  = 1 << DEPTH;
      localparam int HALF  = 1 << (DEPTH - 1);

      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        localparam bit DO_COMB = IS_UP ? (((i + 1) % SPAN) == 0)
                                       : ((((i + 1) % SPAN) == HALF) && (i >= SPAN));
        if (DO_COMB) begin : g_comb
          gp_combine u_gp_combine (
            .gp_hi  (g_lvl[k-1].gp_q[i]),
            .gp_lo  (g_lvl[k-1].gp_q[i-HALF]),
            .gp_res (gp_d[i])
          );
        end else begin : g_pass
          assign gp_d[i] = g_lvl[k-1].gp_q[i];
        end
      end
      assign p_d  = g_lvl[k-1].p_q;
      assign ci_d = g_lvl[k-1].ci_q;
      assign v_d  = g_lvl[k-1].v_q;
    end

    if (PIPE != 0) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= 1'b0;
        end else if (advance) begin
          v_q <= v_d;
        end
      end

      always_ff @(posedge clk) begin
        if (advance) begin
          gp_q <= gp_d;
          p_q  <= p_d;
          ci_q <= ci_d;
        end
      end
    end else begin : g_wire
      assign gp_q = gp_d;
      assign p_q  = p_d;
      assign ci_q = ci_d;
      assign v_q  = v_d;
    end
  end

  gp_t  [WIDTH-1:0] fin_gp;
  logic [WIDTH-1:0] fin_p;
  logic             fin_ci;
  logic             fin_v;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_d;
  logic             co_d;
  logic             ovf_d;

  assign fin_gp = g_lvl[LEVELS].gp_q;
  assign fin_p  = g_lvl[LEVELS].p_q;
  assign fin_ci = g_lvl[LEVELS].ci_q;
  assign fin_v  = g_lvl[LEVELS].v_q;

  // fin_gp[i] now covers bits [i:0], so each carry needs one AND-OR.
  always_comb begin
    carry    = '0;
    carry[0] = fin_ci;
    for (int i = 1; i < WIDTH; i++) begin
      carry[i] = fin_gp[i-1].g | (fin_gp[i-1].p & fin_ci);
    end
    co_d  = fin_gp[WIDTH-1].g | (fin_gp[WIDTH-1].p & fin_ci);
    sum_d = fin_p ^ carry;
    ovf_d = carry[WIDTH-1] ^ co_d;
  end

  // Result fields load only on a real beat so a bubble never disturbs them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
    end else if (advance) begin
      out_valid <= fin_v;
      if (fin_v) begin
        sum   <= sum_d;
        c_out <= co_d;
        ovf   <= ovf_d;
      end
    end
  end

endmodule
